// File: rtl/rvc_mem_defs.sv
// Shared memory-side definitions for the RVC caches and the main-memory arbiter.
package rvc_mem_defs;

  localparam int unsigned DEF_ADDR_W = 28;
  localparam int unsigned DEF_DATA_W = 128;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_BUSY_I  = 2'd1,
    ARB_BUSY_D  = 2'd2,
    ARB_RELEASE = 2'd3
  } arb_state_e;

  // D wins when alone, when it has fixed priority, or when I was served last.
  function automatic logic arb_pick_d(input logic i_req, input logic d_req,
                                      input logic prio, input logic last);
    return d_req & (~i_req | prio | ~last);
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Shares the single main-memory line port between the I-cache and the D-cache,
// registering the winning request and steering the completion strobe back.
module mem_arbiter
  import rvc_mem_defs::*;
#(
  parameter bit          DCACHE_PRIO = 1'b0,
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned DATA_W      = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              i_mem_read,
  input  logic [ADDR_W-1:0] i_mem_addr,
  output logic [DATA_W-1:0] i_mem_rdata,
  output logic              i_mem_ready,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_addr,
  input  logic [DATA_W-1:0] d_mem_wdata,
  output logic [DATA_W-1:0] d_mem_rdata,
  output logic              d_mem_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  arb_state_e        r_state, w_state_nxt;
  logic              r_last, w_last_nxt;
  logic              r_mem_read, w_mem_read_nxt;
  logic              r_mem_write, w_mem_write_nxt;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_nxt;
  logic              w_i_req, w_d_req, w_grant_d;
  logic              w_i_ready, w_d_ready;

  assign w_i_req   = i_mem_read;
  assign w_d_req   = d_mem_read | d_mem_write;
  assign w_grant_d = arb_pick_d(w_i_req, w_d_req, DCACHE_PRIO, r_last);

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      r_last      <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_last      <= w_last_nxt;
      r_mem_read  <= w_mem_read_nxt;
      r_mem_write <= w_mem_write_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_last_nxt      = r_last;
    w_mem_read_nxt  = r_mem_read;
    w_mem_write_nxt = r_mem_write;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_i_ready       = 1'b0;
    w_d_ready       = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (w_grant_d) begin
          // A simultaneous read+write from the D-cache is issued as a write only.
          w_state_nxt     = ARB_BUSY_D;
          w_mem_read_nxt  = d_mem_read & ~d_mem_write;
          w_mem_write_nxt = d_mem_write;
          w_mem_addr_nxt  = d_mem_addr;
          w_mem_wdata_nxt = d_mem_wdata;
        end else if (w_i_req) begin
          w_state_nxt     = ARB_BUSY_I;
          w_mem_read_nxt  = 1'b1;
          w_mem_write_nxt = 1'b0;
          w_mem_addr_nxt  = i_mem_addr;
          w_mem_wdata_nxt = '0;
        end
      end
      ARB_BUSY_I: begin
        if (mem_ready) begin
          w_i_ready       = 1'b1;
          w_last_nxt      = 1'b0;
          w_mem_read_nxt  = 1'b0;
          w_mem_write_nxt = 1'b0;
          w_state_nxt     = ARB_RELEASE;
        end
      end
      ARB_BUSY_D: begin
        if (mem_ready) begin
          w_d_ready       = 1'b1;
          w_last_nxt      = 1'b1;
          w_mem_read_nxt  = 1'b0;
          w_mem_write_nxt = 1'b0;
          w_state_nxt     = ARB_RELEASE;
        end
      end
      ARB_RELEASE: begin
        w_state_nxt = ARB_IDLE;
      end
      default: begin
        w_state_nxt = ARB_IDLE;
      end
    endcase
  end

  assign i_mem_ready = w_i_ready;
  assign d_mem_ready = w_d_ready;
  assign i_mem_rdata = mem_rdata;
  assign d_mem_rdata = mem_rdata;
  assign mem_read    = r_mem_read;
  assign mem_write   = r_mem_write;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter sharing the single 128-bit main-memory port between the read-only instruction cache and the read/write data cache of the RVC pipeline. Both caches keep their memory-side protocol unchanged: hold request and address until `*_mem_ready`, sample read data in the ready cycle, then drop the request. The arbiter registers the winning request onto the memory bus and routes the completion back. It guarantees one idle memory cycle between transactions and starvation-free round-robin sharing.

## Interface
Parameters:
- `DCACHE_PRIO`, 0: 0 = round-robin on conflict; 1 = D-cache always wins conflicts.
- `ADDR_W`, 28: block address width (word address bits [29:2]).
- `DATA_W`, 128: memory line width.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `proc_reset`  in  1  synchronous, active-high reset.
- `i_mem_read`  in  1  I-cache line read request.
- `i_mem_addr`  in  ADDR_W  I-cache block address.
- `i_mem_rdata`  out  DATA_W  read data to I-cache.
- `i_mem_ready`  out  1  I-cache completion strobe.
- `d_mem_read`  in  1  D-cache line read request.
- `d_mem_write`  in  1  D-cache line write-back request.
- `d_mem_addr`  in  ADDR_W  D-cache block address.
- `d_mem_wdata`  in  DATA_W  D-cache write-back data.
- `d_mem_rdata`  out  DATA_W  read data to D-cache.
- `d_mem_ready`  out  1  D-cache completion strobe.
- `mem_read`, `mem_write`  out  1  memory commands (registered).
- `mem_addr`  out  ADDR_W  memory address (registered).
- `mem_wdata`  out  DATA_W  memory write data (registered).
- `mem_rdata`  in  DATA_W  memory read data, valid when `mem_ready`=1.
- `mem_ready`  in  1  memory completion strobe.

## Operation
- States: IDLE, BUSY_I, BUSY_D, RELEASE. `last` is a 1-bit pointer: 0 = I was granted last, 1 = D was granted last.
- IDLE:
  - Requests: `i_req`=`i_mem_read`; `d_req`=`d_mem_read|d_mem_write`.
  - Only one requester asserts: grant it.
  - Both assert, `DCACHE_PRIO`=1: grant D.
  - Both assert, `DCACHE_PRIO`=0: grant the requester not equal to `last`.
  - On grant: latch addr, wdata (D only) and command into the memory output registers, then go to BUSY_x.
- BUSY_x:
  - Hold `mem_*` registers constant.
  - Input changes from either cache are ignored until completion.
  - On `mem_ready`=1: pulse `x_mem_ready` combinationally in the same cycle, set `last`=x, clear `mem_read`/`mem_write` at the edge, go to RELEASE.
- RELEASE: one cycle with the memory commands low. The just-served cache drops its request here. Then go to IDLE.
- `i_mem_rdata` = `d_mem_rdata` = `mem_rdata` (pass-through). Only the ready strobe is steered.
- `x_mem_ready` is 0 whenever x is not the current BUSY owner. `mem_ready` arriving in IDLE or RELEASE is ignored.
- `d_mem_read` and `d_mem_write` high together is a protocol error. The arbiter issues a write only (`mem_write`=1, `mem_read`=0).
- I-cache never writes: in BUSY_I, `mem_write`=0 and `mem_wdata`=0.

## Timing
- Reset (edge with `proc_reset`=1) sets:
  - state IDLE, `last`=0;
  - `mem_read`=`mem_write`=0, `mem_addr`=0, `mem_wdata`=0;
  - `i_mem_ready`=`d_mem_ready`=0.
- Reset mid-transaction abandons the memory access. Commands are low from the cycle after the reset edge.
- Grant latency: a request first seen in IDLE at cycle N drives memory commands from cycle N+1.
- Completion is the cycle `mem_ready`=1 (cycle M). RELEASE is M+1. A new grant decision is made in IDLE at M+2, with commands on the bus at M+3.
- Minimum occupancy per transaction: memory latency + 3 cycles. A single waiting requester waits at most one full transaction.
- Memory sees its commands deasserted for at least 2 consecutive cycles between transactions (RELEASE and the IDLE decision cycle).

## Structure
- Shared package/include `rvc_mem_defs`: state encodings (`ARB_IDLE`=2'd0, `ARB_BUSY_I`=2'd1, `ARB_BUSY_D`=2'd2, `ARB_RELEASE`=2'd3) plus `ADDR_W`/`DATA_W` defaults. The caches reuse the widths.
- Single module; no sub-module needed. The grant pick is a few lines of combinational logic beside the FSM.
- Top level: `cache_read_only` and the D-cache each connect their `mem_*` port to the I-side or D-side of `mem_arbiter`. The arbiter's `mem_*` port drives main memory.

## Test plan
- Reset with both requests high → after the reset edge all memory outputs are 0, both ready strobes are 0, and state is IDLE. On the first cycle after `proc_reset` falls, D wins, because `last`=0 after reset.
- Lone I read, addr 28'h0000012, memory latency 4 → `mem_read`=1 with `mem_addr`=28'h0000012 one cycle later. `i_mem_ready` pulses exactly in the `mem_ready` cycle with `i_mem_rdata`=`mem_rdata`. `d_mem_ready` stays 0 throughout.
- I and D read requests rise in the same cycle, `DCACHE_PRIO`=0, `last`=0 → D granted first, then I. Commands are low for 2 cycles between the transactions.
- Same stimulus with `DCACHE_PRIO`=1 → D granted on every conflict, including back-to-back repeats.
- D write-back, addr 28'h00000A0, wdata 128'hDEAD…BEEF, immediately followed by a D read of 28'h00000B0 → memory sees the write, a gap, then the read. The read data reaches only D via `d_mem_ready`.
- `proc_reset` asserted in BUSY_D mid-latency → commands drop after the reset edge, `d_mem_ready` is never pulsed, and a late `mem_ready` in IDLE is ignored.
